fft_pingpong_scheduler: RTL and testbench
=========================================

Name: fft_pingpong_scheduler

Overview:
- Sequences the FFT datapath: two single-port 1024x32 sample RAMs in ping-pong and the pipelined FFT core (start / e_done / unload / dv handshakes).
- Strobed input samples fill one bank while the other bank streams into the core.
- Also initialises the core: sclr, then a one-cycle scale schedule write.
- Drops whole frames when the core cannot accept the next one, and counts launched and dropped frames.

Parameters:
- LOG2N, 10, log2 of the FFT length; N = 2^LOG2N; RAM address width = LOG2N.
- START_LEAD, 0, cycles between the start_fft_core pulse and the first read address (aligns RAM read latency with core input timing).
- CNT_W, 16, width of the frame and drop counters.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- strobe  in  1  input sample valid; one sample per asserted cycle
- e_done_fft_core  in  1  core early-done: transform complete, ready to unload
- dv_fft_core  in  1  core output data valid
- sclr_fft_core  out  1  core synchronous clear
- scale_sch_we_fft_core  out  1  scale schedule write enable
- start_fft_core  out  1  core load-start pulse
- unload_fft_core  out  1  core unload pulse
- wr_en_ram_0  out  1  write enable for bank 0
- wr_en_ram_1  out  1  write enable for bank 1
- addr_ram_0  out  LOG2N  bank 0 address
- addr_ram_1  out  LOG2N  bank 1 address
- sel_ram  out  1  output mux select; 1 = core reads bank 0, 0 = core reads bank 1
- frame_count  out  CNT_W  frames launched into the core (wraps)
- drop_count  out  CNT_W  frames dropped on overrun (wraps)
- overrun  out  1  one-cycle pulse when a frame is dropped

Behaviour:
- Reset applies on the clock edge while reset=1. Every output, counter, wr_cnt and rd_addr goes to 0; wr_bank = 0; both FSMs enter their initial state.
- A reset asserted mid-frame abandons the in-flight frame and all RAM contents. No partial frame is ever launched afterwards.
- Init FSM: INIT_CLR (sclr_fft_core=1 for 1 cycle) -> INIT_SCH (scale_sch_we_fft_core=1 for 1 cycle) -> READY.
- Strobes arriving during INIT_CLR or INIT_SCH are ignored; writing starts in READY.
- Write side (READY only):
  - wr_en_ram_<wr_bank> = strobe; the other bank's write enable is 0.
  - The write address is wr_cnt. wr_cnt increments on each strobe and wraps N-1 -> 0.
- Frame complete: a strobe with wr_cnt = N-1.
  - If the read FSM is in R_IDLE on that cycle: toggle wr_bank on the next edge, increment frame_count, and enter R_LEAD (or R_LOAD when START_LEAD = 0).
  - Otherwise: overrun=1 for that cycle, drop_count increments, wr_bank stays unchanged. The next frame overwrites the same bank from address 0.
- Sample ordering across a swap: the strobe in the wrap cycle writes address N-1 of the old bank. The next strobe writes address 0 of the new bank.
- sel_ram = wr_bank, so the core always reads the bank that is not being written.
- Address mux: addr_ram_k = wr_cnt when k = wr_bank, else rd_addr.
- Read FSM states:
  - R_IDLE: wait for a frame complete.
  - R_LEAD: start_fft_core=1 on entry; count START_LEAD cycles.
  - R_LOAD: rd_addr issues 0..N-1 on consecutive cycles, then goes to R_WAIT. When START_LEAD = 0, start_fft_core=1 in the cycle rd_addr = 0.
  - R_WAIT: on e_done_fft_core=1, go to R_UNLOAD with unload_fft_core=1 for exactly 1 cycle.
  - R_UNLOAD: wait for dv_fft_core to rise, then fall; return to R_IDLE on the fall.
- rd_addr returns to 0 when R_LOAD exits.
- start and unload are strict single-cycle pulses.
- e_done outside R_WAIT and dv outside R_UNLOAD are ignored.
- The same-cycle event combination of frame complete and the read FSM returning to R_IDLE counts as not idle: overrun.
- A launched frame is never re-read. A bank is never written and read in the same cycle.

Test Plan:
- Init: release reset, hold strobe=1 -> sclr=1 at cycle 1, scale_sch_we=1 at cycle 2. No wr_en during init. First write is bank 0, addr 0, at cycle 3.
- Continuous fill, LOG2N=3 (N=8), START_LEAD=0: 8 strobes -> sel_ram=1, start pulse with addr_ram_0=0, addr_ram_0 reads 0..7. The 9th strobe writes addr_ram_1=0. frame_count=1.
- Handshake: e_done pulse in R_WAIT -> unload=1 for 1 cycle. dv high for 8 cycles then low -> read FSM returns to idle. The next full frame launches from bank 1 with sel_ram=0.
- Overrun, N=8: withhold e_done while 16 more strobes arrive -> overrun pulses twice, drop_count=2, wr_bank unchanged, frame_count unchanged.
- Boundary: a frame completes in the same cycle dv falls -> overrun=1, frame not launched. The following frame launches normally.
- Reset mid-load: assert reset at rd_addr=4 -> all outputs 0 the next cycle, init sequence repeats, no start until 8 fresh strobes.

Source files
------------

// File: rtl/fft_pingpong_scheduler.sv
// fft_pingpong_scheduler: ping-pong sample banks feeding a pipelined FFT core, with core init and frame-drop accounting
module fft_pingpong_scheduler #(
    parameter int LOG2N      = 10,
    parameter int START_LEAD = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             strobe,
    input  logic             e_done_fft_core,
    input  logic             dv_fft_core,
    output logic             sclr_fft_core,
    output logic             scale_sch_we_fft_core,
    output logic             start_fft_core,
    output logic             unload_fft_core,
    output logic             wr_en_ram_0,
    output logic             wr_en_ram_1,
    output logic [LOG2N-1:0] addr_ram_0,
    output logic [LOG2N-1:0] addr_ram_1,
    output logic             sel_ram,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             overrun
);
    localparam logic [LOG2N-1:0] LAST = '1;

    // I_RST holds every output low for the cycle right after reset so the
    // clear pulse starts only once reset has been released.
    typedef enum logic [1:0] {I_RST, I_CLR, I_SCH, I_READY} init_t;
    typedef enum logic [2:0] {R_IDLE, R_LEAD, R_LOAD, R_WAIT, R_UNLOAD} rd_t;

    init_t            init_q, init_d;
    rd_t              rd_q, rd_d;
    logic             wr_bank_q, wr_bank_d;
    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic [LOG2N-1:0] rd_addr_q, rd_addr_d;
    logic [15:0]      lead_q, lead_d;
    logic             dv_seen_q, dv_seen_d;
    logic             unload_q, unload_d;
    logic [CNT_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             wr, frame_done, launch;

    assign wr         = (init_q == I_READY) && strobe;
    assign frame_done = wr && (wr_cnt_q == LAST);
    assign launch     = frame_done && (rd_q == R_IDLE);

    assign sclr_fft_core         = (init_q == I_CLR);
    assign scale_sch_we_fft_core = (init_q == I_SCH);
    assign unload_fft_core       = unload_q;
    assign wr_en_ram_0           = wr && !wr_bank_q;
    assign wr_en_ram_1           = wr && wr_bank_q;
    assign addr_ram_0            = wr_bank_q ? rd_addr_q : wr_cnt_q;
    assign addr_ram_1            = wr_bank_q ? wr_cnt_q : rd_addr_q;
    assign sel_ram               = wr_bank_q;
    assign frame_count           = frame_q;
    assign drop_count            = drop_q;
    assign overrun               = frame_done && (rd_q != R_IDLE);

    // Init sequencing, write pointer, bank swap and frame/drop counters
    always_comb begin
        init_d    = (init_q == I_RST) ? I_CLR : (init_q == I_CLR) ? I_SCH : I_READY;
        wr_cnt_d  = wr ? wr_cnt_q + LOG2N'(1) : wr_cnt_q;
        wr_bank_d = launch ? !wr_bank_q : wr_bank_q;
        frame_d   = launch ? frame_q + CNT_W'(1) : frame_q;
        drop_d    = overrun ? drop_q + CNT_W'(1) : drop_q;
    end

    // Read FSM: stream the full bank into the core, then run the unload handshake
    always_comb begin
        rd_d           = rd_q;
        rd_addr_d      = rd_addr_q;
        lead_d         = lead_q;
        dv_seen_d      = dv_seen_q;
        unload_d       = 1'b0;
        start_fft_core = 1'b0;
        case (rd_q)
            R_IDLE: begin
                if (launch) begin
                    rd_d      = (START_LEAD == 0) ? R_LOAD : R_LEAD;
                    lead_d    = '0;
                    dv_seen_d = 1'b0;
                end
            end
            R_LEAD: begin
                start_fft_core = (lead_q == '0);
                lead_d         = lead_q + 16'd1;
                if (lead_q == 16'(START_LEAD - 1))
                    rd_d = R_LOAD;
            end
            R_LOAD: begin
                start_fft_core = (START_LEAD == 0) && (rd_addr_q == '0);
                rd_addr_d      = rd_addr_q + LOG2N'(1);
                if (rd_addr_q == LAST)
                    rd_d = R_WAIT;
            end
            R_WAIT: begin
                if (e_done_fft_core) begin
                    rd_d     = R_UNLOAD;
                    unload_d = 1'b1;
                end
            end
            R_UNLOAD: begin
                if (dv_fft_core)
                    dv_seen_d = 1'b1;
                if (dv_seen_q && !dv_fft_core)
                    rd_d = R_IDLE;
            end
            default: rd_d = R_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            init_q    <= I_RST;
            rd_q      <= R_IDLE;
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_addr_q <= '0;
            lead_q    <= '0;
            dv_seen_q <= 1'b0;
            unload_q  <= 1'b0;
            frame_q   <= '0;
            drop_q    <= '0;
        end else begin
            init_q    <= init_d;
            rd_q      <= rd_d;
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_addr_q <= rd_addr_d;
            lead_q    <= lead_d;
            dv_seen_q <= dv_seen_d;
            unload_q  <= unload_d;
            frame_q   <= frame_d;
            drop_q    <= drop_d;
        end
    end
endmodule

// File: tb/tb_fft_pingpong_scheduler.sv
// tb_fft_pingpong_scheduler: directed scenarios plus random traffic against a frame-level reference model
module tb_fft_pingpong_scheduler;
    localparam int LOG2N = 3;
    localparam int N     = 8;
    localparam int CW    = 16;

    logic clock = 1'b0, reset = 1'b1, strobe = 1'b0, e_done = 1'b0, dv = 1'b0;
    logic sclr, sch_we, start, unload, wr0, wr1, sel, ovr;
    logic [LOG2N-1:0] addr0, addr1;
    logic [CW-1:0] frames_o, drops_o;
    logic [45:0] obs, exp_v;

    int total = 0, bad = 0;
    // Model: cycles since reset (saturating), fill level, write bank, and a
    // busy read side described by cycles since launch plus handshake flags.
    int age, fill, bank, busy, lcyc, eg, dg, unl, frames, drops;

    fft_pingpong_scheduler #(.LOG2N(LOG2N), .START_LEAD(0), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .strobe(strobe),
        .e_done_fft_core(e_done), .dv_fft_core(dv),
        .sclr_fft_core(sclr), .scale_sch_we_fft_core(sch_we),
        .start_fft_core(start), .unload_fft_core(unload),
        .wr_en_ram_0(wr0), .wr_en_ram_1(wr1),
        .addr_ram_0(addr0), .addr_ram_1(addr1), .sel_ram(sel),
        .frame_count(frames_o), .drop_count(drops_o), .overrun(ovr)
    );

    assign obs = {sclr, sch_we, start, unload, wr0, wr1, addr0, addr1, sel, frames_o, drops_o, ovr};

    always #5 clock = ~clock;

    function automatic logic [45:0] model_out();
        logic w, fc;
        logic [2:0] rd, a0, a1;
        w  = (age >= 3) && strobe;
        fc = w && (fill == N - 1);
        rd = (busy != 0 && lcyc >= 1 && lcyc <= N) ? 3'(lcyc - 1) : 3'd0;
        a0 = (bank == 0) ? 3'(fill) : rd;
        a1 = (bank == 1) ? 3'(fill) : rd;
        return {age == 1, age == 2, busy != 0 && lcyc == 1, unl != 0,
                w && bank == 0, w && bank == 1, a0, a1, 1'(bank),
                16'(frames), 16'(drops), fc && busy != 0};
    endfunction

    task automatic drive(input logic r, s, e, d);
        reset = r; strobe = s; e_done = e; dv = d;
        #1;
        exp_v = model_out();
    endtask

    task automatic adv();
        logic w, fc;
        int ob, oeg, odg;
        @(posedge clock);
        if (reset) begin
            age = 0; fill = 0; bank = 0; busy = 0; lcyc = 0;
            eg = 0; dg = 0; unl = 0; frames = 0; drops = 0;
        end else begin
            w = (age >= 3) && strobe;
            fc = w && (fill == N - 1);
            ob = busy; oeg = eg; odg = dg;
            unl = (ob != 0 && lcyc > N && oeg == 0 && e_done) ? 1 : 0;
            if (ob != 0) begin
                if (lcyc > N && oeg == 0 && e_done) eg = 1;
                if (oeg != 0) begin
                    if (dv) dg = 1;
                    if (odg != 0 && !dv) busy = 0;
                end
                if (lcyc < 1000) lcyc++;
            end
            if (fc && ob == 0) begin
                bank ^= 1; frames++; busy = 1; lcyc = 1; eg = 0; dg = 0;
            end
            if (fc && ob != 0) drops++;
            if (w) fill = (fill + 1) % N;
            if (age < 3) age++;
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0); adv();
        drive(1, 1, 1, 1); adv();
        drive(1, 1, 0, 0);
        total++;
        if (obs !== 46'd0) begin bad++; $display("FAIL reset_zero got=%h exp=0", obs); end
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_model got=%h exp=%h", obs, exp_v); end
        adv();
    endtask

    task automatic test_init();
        for (int c = 0; c < 4; c++) begin
            drive(0, 1, 0, 0);
            total++;
            if ({sclr, sch_we, wr0, wr1, addr0} !== {c == 1, c == 2, c == 3, 1'b0, 3'd0}) begin
                bad++;
                $display("FAIL init c=%0d got=%b exp=%b", c, {sclr, sch_we, wr0, wr1, addr0}, {c == 1, c == 2, c == 3, 1'b0, 3'd0});
            end
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL init_model c=%0d got=%h exp=%h", c, obs, exp_v); end
            adv();
        end
    endtask

    task automatic test_fill();
        for (int k = 1; k < N; k++) begin
            drive(0, 1, 0, 0);
            total++;
            if (obs !== exp_v || addr0 !== 3'(k)) begin bad++; $display("FAIL fill k=%0d got=%h exp=%h", k, obs, exp_v); end
            adv();
        end
        for (int j = 0; j < N; j++) begin
            drive(0, j == 0, 0, 0);
            total++;
            if ({sel, start, addr0} !== {1'b1, j == 0, 3'(j)}) begin
                bad++;
                $display("FAIL load j=%0d got=%b exp=%b", j, {sel, start, addr0}, {1'b1, j == 0, 3'(j)});
            end
            if (j == 0) begin
                total++;
                if ({wr1, addr1} !== 4'b1000) begin bad++; $display("FAIL ninth_strobe got=%b exp=1000", {wr1, addr1}); end
            end
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL load_model j=%0d got=%h exp=%h", j, obs, exp_v); end
            adv();
        end
        drive(0, 0, 0, 0);
        total++;
        if (frames_o !== 16'd1) begin bad++; $display("FAIL frame_count got=%0d exp=1", frames_o); end
    endtask

    task automatic test_handshake();
        int unl_seen = 0;
        for (int c = 0; c < 14 + N; c++) begin
            drive(0, 0, c == 2, c >= 4 && c < 4 + N);
            if (unload) unl_seen++;
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL hs c=%0d got=%h exp=%h", c, obs, exp_v); end
            adv();
        end
        total++;
        if (unl_seen != 1) begin bad++; $display("FAIL unload_pulses got=%0d exp=1", unl_seen); end
        for (int k = 1; k < N; k++) begin drive(0, 1, 0, 0); adv(); end
        drive(0, 0, 0, 0);
        total++;
        if ({sel, start, addr1, frames_o} !== {1'b0, 1'b1, 3'd0, 16'd2}) begin
            bad++;
            $display("FAIL relaunch got=%b/%b/%0d/%0d exp=0/1/0/2", sel, start, addr1, frames_o);
        end
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL relaunch_model got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_overrun();
        int pulses = 0;
        logic [CW-1:0] d0 = drops_o, f0 = frames_o;
        logic s0 = sel;
        for (int k = 0; k < 2 * N; k++) begin
            drive(0, 1, 0, 0);
            if (ovr) pulses++;
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL ovr k=%0d got=%h exp=%h", k, obs, exp_v); end
            adv();
        end
        drive(0, 0, 0, 0);
        total++;
        if (pulses != 2 || drops_o !== d0 + 16'd2 || frames_o !== f0 || sel !== s0) begin
            bad++;
            $display("FAIL overrun pulses=%0d drops=%0d frames=%0d sel=%b exp 2/%0d/%0d/%b", pulses, drops_o, frames_o, sel, d0 + 16'd2, f0, s0);
        end
    endtask

    task automatic test_boundary();
        logic [CW-1:0] f0;
        for (int g = 0; g < 40 && lcyc <= N; g++) begin drive(0, 0, 0, 0); adv(); end
        drive(0, 0, 1, 0); adv();
        drive(0, 0, 0, 1); adv();
        for (int g = 0; g < 2 * N && fill < N - 1; g++) begin drive(0, 1, 0, 1); adv(); end
        f0 = frames_o;
        drive(0, 1, 0, 0);
        total++;
        if (ovr !== 1'b1) begin bad++; $display("FAIL dv_fall_overrun got=%b exp=1", ovr); end
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL dv_fall_model got=%h exp=%h", obs, exp_v); end
        adv();
        for (int k = 0; k < N; k++) begin
            drive(0, 1, 0, 0);
            total++;
            if (ovr !== 1'b0 || obs !== exp_v) begin bad++; $display("FAIL next_frame k=%0d got=%h exp=%h", k, obs, exp_v); end
            adv();
        end
        drive(0, 0, 0, 0);
        total++;
        if (start !== 1'b1 || frames_o !== f0 + 16'd1) begin
            bad++;
            $display("FAIL boundary_launch start=%b frames=%0d exp 1/%0d", start, frames_o, f0 + 16'd1);
        end
    endtask

    task automatic test_reset_mid();
        for (int g = 0; g < 20 && lcyc != 5; g++) begin drive(0, 0, 0, 0); adv(); end
        drive(1, 0, 0, 0);
        total++;
        if (addr0 !== 3'd4 && addr1 !== 3'd4) begin bad++; $display("FAIL mid_addr got=%0d/%0d exp=4", addr0, addr1); end
        adv();
        for (int c = 0; c < N + 4; c++) begin
            drive(0, 1, 0, 0);
            if (c == 0) begin
                total++;
                if (obs !== 46'd0) begin bad++; $display("FAIL after_reset got=%h exp=0", obs); end
            end
            total++;
            if (start !== (c == N + 3)) begin bad++; $display("FAIL fresh_start c=%0d got=%b exp=%b", c, start, c == N + 3); end
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL reinit_model c=%0d got=%h exp=%h", c, obs, exp_v); end
            adv();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(299) == 0, $urandom_range(3) != 0, $urandom_range(5) == 0, $urandom_range(1) == 0);
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL rand i=%0d got=%h exp=%h", i, obs, exp_v); end
            adv();
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_init();
        test_fill();
        test_handshake();
        test_overrun();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
